pipeline_m: RTL and testbench
=============================

Name: pipeline_m

Overview:
- Memory (M) stage of the 5-stage MIPS pipeline, placed directly downstream of the execute stage.
- Contains the E/M pipeline register, the M-stage store-data forwarding mux, a word-organised data memory with byte/half-word write enables, and the load-data extender.
- Feeds the M/W pipeline register.
- Drives ALUOutput_M back to the execute stage for forwarding.

Parameters:
- DM_WORDS, 4096: number of 32-bit words in data memory; byte address range 0 .. DM_WORDS*4-1.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- Reset  input  1  reset, synchronous, active-high; clock CLK.
- Instr_E  input  32  instruction leaving E.
- ALUOutput  input  32  E-stage result (address / ALU value / PC+8 / HI / LO).
- WriteData_E  input  32  forwarded rt value from E.
- WriteRd_E  input  5  destination register from E.
- PCPlus4_E  input  32  PC+4 of the E instruction.
- ForwardRTM  input  1  1 = replace the registered store data with MUXRFWDOut.
- MUXRFWDOut  input  32  W-stage writeback value.
- Instr_M  output  32  registered instruction.
- ALUOutput_M  output  32  registered ALU result; also the memory byte address.
- WriteRd_M  output  5  registered destination register.
- PCPlus4_M  output  32  registered PC+4.
- DMOut  output  32  extended load data (combinational).
- MemWrite  output  1  high while Instr_M is an in-range store; for bench observation.

Behaviour:
- E/M register: on each posedge with Reset=0, latch Instr_E, ALUOutput, WriteData_E, WriteRd_E and PCPlus4_E. There is no stall or enable; the register updates every cycle.
- Reset: Instr_M, ALUOutput_M, stored WriteData, WriteRd_M and PCPlus4_M all go to 0. Every memory word goes to 0 in the same cycle. Reset overrides a store in the same cycle, so that store does not occur.
- Instr_M = 0 (sll $0) is a bubble: no memory write, DMOut = 0.
- Store data: StoreData = ForwardRTM ? MUXRFWDOut : registered WriteData.
- Decode uses Instr_M[31:26]:
  - sw 101011, sh 101001, sb 101000.
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - All other opcodes do no memory access, and DMOut = 0.
- Addressing:
  - word index = ALUOutput_M[31:2]; in range iff index < DM_WORDS.
  - Low address bits select the lane: sw ignores bits [1:0]; sh/lh/lhu use bit [1] and ignore bit [0]; sb/lb/lbu use bits [1:0].
  - Half-word lane: bit [1]=0 selects bits [15:0], 1 selects bits [31:16].
  - Byte lane: n = bits [1:0] selects bits [8n+7:8n] (little-endian).
- Writes occur at the posedge that ends the store's M cycle.
  - sw writes all 4 bytes.
  - sh writes the 2 bytes of the selected lane from StoreData[15:0].
  - sb writes the selected byte from StoreData[7:0].
  - Unselected bytes of the word are preserved.
  - Out-of-range stores are dropped, and MemWrite=0 for them.
- Reads are combinational from the current array contents.
  - lw returns the word.
  - lh/lb sign-extend the selected lane; lhu/lbu zero-extend it.
  - An out-of-range load returns 0.
- Ordering: a store to address A in M at cycle t is visible to a load of A in M at cycle t+1 or later. A store and a load are never in M together.
- Latency: a value presented on the E inputs appears on the *_M outputs one cycle later. DMOut is valid in the same cycle that Instr_M holds the load.

Test Plan:
- Reset asserted for 2 cycles with nonzero inputs -> all *_M outputs 0, MemWrite 0. Then lw from 0x0 and 0x3FFC -> DMOut 0.
- sw 0x12345678 to 0x10, then lw 0x10, lb 0x11, lbu 0x13, lh 0x12, lhu 0x10 -> DMOut 0x12345678, 0x00000056, 0x00000012, 0x00001234, 0x00005678.
- Word 0x20 = 0xFFFFFFFF; sb 0x00 to 0x21; sh 0x8001 to 0x22 -> lw 0x20 = 0x800100FF. Then lb 0x23 = 0xFFFFFF80, lhu 0x22 = 0x00008001.
- ForwardRTM=1, MUXRFWDOut=0xCAFEBABE, registered WriteData 0x0, sw to 0x40 -> lw 0x40 = 0xCAFEBABE. Repeat with ForwardRTM=0 -> 0x0.
- sw to byte address DM_WORDS*4 (0x4000) -> MemWrite 0, no word changes (spot-check 0x0 and 0x3FFC). lw 0x4000 -> DMOut 0.
- sw 0xAAAA5555 to 0x80 with Reset high on that store's M-cycle edge -> lw 0x80 = 0. Pipeline pass-through: Instr_E/PCPlus4_E/WriteRd_E = 0x8C010080/0x3004/1 -> Instr_M/PCPlus4_M/WriteRd_M show the same values one cycle later.

Source files
------------

// File: rtl/pipeline_m.sv
// Memory stage of the 5-stage MIPS pipeline: E/M register, store-data forwarding,
// byte-lane data memory and load-data extension.
module pipeline_m #(
  parameter int DM_WORDS = 4096
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Instr_E,
  input  logic [31:0] ALUOutput,
  input  logic [31:0] WriteData_E,
  input  logic [4:0]  WriteRd_E,
  input  logic [31:0] PCPlus4_E,
  input  logic        ForwardRTM,
  input  logic [31:0] MUXRFWDOut,
  output logic [31:0] Instr_M,
  output logic [31:0] ALUOutput_M,
  output logic [4:0]  WriteRd_M,
  output logic [31:0] PCPlus4_M,
  output logic [31:0] DMOut,
  output logic        MemWrite
);

  localparam int AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

  logic [31:0] r_instr;
  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [31:0] r_pc4;
  logic [31:0] r_mem [0:DM_WORDS-1];

  logic [5:0]    w_op;
  logic [AW-1:0] w_addr;
  logic          w_in_range;
  logic [31:0]   w_store_data;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_data;
  logic [31:0]   w_word;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;

  assign w_op         = r_instr[31:26];
  assign w_addr       = r_alu[AW+1:2];
  assign w_in_range   = (r_alu[31:2] < 30'(DM_WORDS));
  assign w_store_data = ForwardRTM ? MUXRFWDOut : r_wdata;

  assign Instr_M     = r_instr;
  assign ALUOutput_M = r_alu;
  assign WriteRd_M   = r_rd;
  assign PCPlus4_M   = r_pc4;
  assign MemWrite    = |w_be;

  // E/M pipeline register, no stall
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_instr <= 32'h0000_0000;
      r_alu   <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_rd    <= 5'd0;
      r_pc4   <= 32'h0000_0000;
    end else begin
      r_instr <= Instr_E;
      r_alu   <= ALUOutput;
      r_wdata <= WriteData_E;
      r_rd    <= WriteRd_E;
      r_pc4   <= PCPlus4_E;
    end
  end

  // Store decode: byte enables and lane-replicated write data
  always_comb begin
    w_be        = 4'b0000;
    w_lane_data = 32'h0000_0000;
    case (w_op)
      OP_SW: begin
        w_be        = 4'b1111;
        w_lane_data = w_store_data;
      end
      OP_SH: begin
        w_be        = r_alu[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{w_store_data[15:0]}};
      end
      OP_SB: begin
        w_be        = 4'b0001 << r_alu[1:0];
        w_lane_data = {4{w_store_data[7:0]}};
      end
      default: begin
        w_be        = 4'b0000;
        w_lane_data = 32'h0000_0000;
      end
    endcase
    if (!w_in_range) begin
      w_be = 4'b0000;
    end else begin
      w_be = w_be;
    end
  end

  // Data memory: reset clears every word and wins over a concurrent store
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_addr][8*b +: 8] <= w_lane_data[8*b +: 8];
        end
      end
    end
  end

  // Lane selection for loads
  always_comb begin
    w_word = 32'h0000_0000;
    if (w_in_range) begin
      w_word = r_mem[w_addr];
    end else begin
      w_word = 32'h0000_0000;
    end
    w_half = r_alu[1] ? w_word[31:16] : w_word[15:0];
    case (r_alu[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  // Load extension; bubbles and non-loads read as zero
  always_comb begin
    DMOut = 32'h0000_0000;
    case (w_op)
      OP_LW:   DMOut = w_word;
      OP_LH:   DMOut = {{16{w_half[15]}}, w_half};
      OP_LHU:  DMOut = {16'h0000, w_half};
      OP_LB:   DMOut = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  DMOut = {24'h00_0000, w_byte};
      default: DMOut = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_pipeline_m.sv
// Randomised and directed bench for pipeline_m against a byte-array memory model.
module tb_pipeline_m;

  localparam int DM_WORDS = 4096;
  localparam int DMB      = DM_WORDS * 4;

  localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Instr_E = 32'h0, ALUOutput = 32'h0, WriteData_E = 32'h0, PCPlus4_E = 32'h0;
  logic [4:0]  WriteRd_E = 5'd0;
  logic        ForwardRTM = 1'b0;
  logic [31:0] MUXRFWDOut = 32'h0;
  logic [31:0] Instr_M, ALUOutput_M, PCPlus4_M, DMOut;
  logic [4:0]  WriteRd_M;
  logic        MemWrite;

  pipeline_m #(.DM_WORDS(DM_WORDS)) dut (
    .CLK(CLK), .Reset(Reset), .Instr_E(Instr_E), .ALUOutput(ALUOutput),
    .WriteData_E(WriteData_E), .WriteRd_E(WriteRd_E), .PCPlus4_E(PCPlus4_E),
    .ForwardRTM(ForwardRTM), .MUXRFWDOut(MUXRFWDOut), .Instr_M(Instr_M),
    .ALUOutput_M(ALUOutput_M), .WriteRd_M(WriteRd_M), .PCPlus4_M(PCPlus4_M),
    .DMOut(DMOut), .MemWrite(MemWrite)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // model state: byte-addressed memory and the expected M-stage contents
  logic [7:0]  mb [0:DMB-1];
  logic [31:0] e_instr, e_alu, e_wd, e_pc4;
  logic [4:0]  e_rd;
  logic        pend_st = 1'b0;
  logic [5:0]  pend_op;
  logic [31:0] pend_addr, pend_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h expected=%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_store(input logic [5:0] op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr);
    int a;
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    if (addr >= 32'(DMB)) return 32'h0;
    a = int'(addr);
    w = {mb[(a/4)*4+3], mb[(a/4)*4+2], mb[(a/4)*4+1], mb[(a/4)*4]};
    h = {mb[(a/2)*2+1], mb[(a/2)*2]};
    b = mb[a];
    case (op)
      LW:      return w;
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'h0, h};
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'h0, b};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] d);
    int a;
    if (addr < 32'(DMB)) begin
      a = int'(addr);
      case (op)
        SW: for (int k = 0; k < 4; k++) mb[(a/4)*4+k] = d[8*k +: 8];
        SH: for (int k = 0; k < 2; k++) mb[(a/2)*2+k] = d[8*k +: 8];
        SB: mb[a] = d[7:0];
        default: ;
      endcase
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < DMB; i++) mb[i] = 8'h00;
    e_instr = 32'h0; e_alu = 32'h0; e_wd = 32'h0; e_pc4 = 32'h0; e_rd = 5'd0;
    pend_st = 1'b0;
  endtask

  // Present one instruction to E, follow it into M, compare every M output.
  // rst_next raises Reset for the edge that ends this instruction's M cycle.
  task automatic issue(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] pc4, input logic fwd,
                       input logic [31:0] mux, input logic rst_next);
    logic [5:0]  op;
    logic [31:0] sd;
    logic        was_rst;
    Instr_E = instr; ALUOutput = alu; WriteData_E = wd; WriteRd_E = rd; PCPlus4_E = pc4;
    @(posedge CLK);
    was_rst = Reset;
    if (was_rst) begin
      m_clear();
    end else begin
      if (pend_st) m_store(pend_op, pend_addr, pend_data);
      pend_st = 1'b0;
      e_instr = instr; e_alu = alu; e_wd = wd; e_rd = rd; e_pc4 = pc4;
    end
    #1;
    Reset = rst_next; ForwardRTM = fwd; MUXRFWDOut = mux;
    #1;
    op = e_instr[31:26];
    sd = fwd ? mux : e_wd;
    chk("Instr_M", Instr_M, e_instr);
    chk("ALUOutput_M", ALUOutput_M, e_alu);
    chk("WriteRd_M", {27'h0, WriteRd_M}, {27'h0, e_rd});
    chk("PCPlus4_M", PCPlus4_M, e_pc4);
    chk("DMOut", DMOut, m_load(op, e_alu));
    chk("MemWrite", {31'h0, MemWrite}, {31'h0, is_store(op) && (e_alu < 32'(DMB))});
    if (is_store(op)) begin
      pend_st = 1'b1; pend_op = op; pend_addr = e_alu; pend_data = sd;
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h0123456};
  endfunction

  task automatic st(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    issue(mk(op), a, d, 5'd0, 32'h100, 1'b0, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic ld(input logic [5:0] op, input logic [31:0] a, input string nm,
                    input logic [31:0] lit);
    issue(mk(op), a, 32'h5A5A_5A5A, 5'd3, 32'h200, 1'b0, 32'h0, 1'b0);
    chk(nm, DMOut, lit);
  endtask

  logic [5:0] ops [10];

  initial begin
    ops = '{SW, SH, SB, LW, LH, LHU, LB, LBU, 6'b000000, 6'b001000};

    // reset for two cycles with nonzero inputs on E
    Reset = 1'b1;
    Instr_E = 32'hAC01_0010; ALUOutput = 32'h10; WriteData_E = 32'hFFFF_FFFF;
    WriteRd_E = 5'd7; PCPlus4_E = 32'h44;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_Instr_M", Instr_M, 32'h0);
    chk("rst_ALUOutput_M", ALUOutput_M, 32'h0);
    chk("rst_WriteRd_M", {27'h0, WriteRd_M}, 32'h0);
    chk("rst_PCPlus4_M", PCPlus4_M, 32'h0);
    chk("rst_MemWrite", {31'h0, MemWrite}, 32'h0);
    m_clear();
    Reset = 1'b0;

    ld(LW, 32'h0, "lw_0_after_rst", 32'h0);
    ld(LW, 32'h3FFC, "lw_3ffc_after_rst", 32'h0);

    st(SW, 32'h10, 32'h1234_5678);
    ld(LW, 32'h10, "lw_10", 32'h1234_5678);
    ld(LB, 32'h11, "lb_11", 32'h0000_0056);
    ld(LBU, 32'h13, "lbu_13", 32'h0000_0012);
    ld(LH, 32'h12, "lh_12", 32'h0000_1234);
    ld(LHU, 32'h10, "lhu_10", 32'h0000_5678);

    st(SW, 32'h20, 32'hFFFF_FFFF);
    st(SB, 32'h21, 32'h0000_0000);
    st(SH, 32'h22, 32'h0000_8001);
    ld(LW, 32'h20, "lw_20_merge", 32'h8001_00FF);
    ld(LB, 32'h23, "lb_23", 32'hFFFF_FF80);
    ld(LHU, 32'h22, "lhu_22", 32'h0000_8001);

    issue(mk(SW), 32'h40, 32'h0, 5'd0, 32'h0, 1'b1, 32'hCAFE_BABE, 1'b0);
    ld(LW, 32'h40, "lw_40_fwd", 32'hCAFE_BABE);
    issue(mk(SW), 32'h40, 32'h0, 5'd0, 32'h0, 1'b0, 32'hCAFE_BABE, 1'b0);
    ld(LW, 32'h40, "lw_40_nofwd", 32'h0);

    st(SW, 32'h4000, 32'h7777_7777);
    chk("oor_MemWrite", {31'h0, MemWrite}, 32'h0);
    ld(LW, 32'h0, "oor_lw_0", 32'h0);
    ld(LW, 32'h3FFC, "oor_lw_3ffc", 32'h0);
    ld(LW, 32'h4000, "oor_lw_4000", 32'h0);

    // store whose M-cycle edge sees Reset; the following E instruction is wiped too
    issue(mk(SW), 32'h80, 32'hAAAA_5555, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    issue(mk(LW), 32'h10, 32'h0, 5'd9, 32'h99, 1'b0, 32'h0, 1'b0);
    chk("rst_wipes_E", Instr_M, 32'h0);
    ld(LW, 32'h80, "lw_80_after_rst_store", 32'h0);

    issue(32'h8C01_0080, 32'h80, 32'h0, 5'd1, 32'h3004, 1'b0, 32'h0, 1'b0);
    chk("pass_Instr_M", Instr_M, 32'h8C01_0080);
    chk("pass_PCPlus4_M", PCPlus4_M, 32'h3004);
    chk("pass_WriteRd_M", {27'h0, WriteRd_M}, 32'h1);

    // randomised traffic over a small window plus the memory top and beyond
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [5:0]  op;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 32'h4000 + $urandom_range(0, 255);
      else if (sel == 1) a = 32'h3FF0 + $urandom_range(0, 15);
      else if (sel == 2) a = $urandom();
      else               a = $urandom_range(0, 63);
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 19) == 0) op = 6'($urandom());
      issue({op, 26'($urandom())}, a, $urandom(), 5'($urandom()), $urandom(),
            1'($urandom()), $urandom(), $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
